fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the program-counter register, drives the instruction-memory address, and captures the fetched word into the IF/ID pipeline register. It consumes the next-PC value and branch-taken decision produced by the decode-stage next-PC logic. It handles stalls, exception entry and eret flushes, and flags fetch address errors and branch-delay-slot membership for CP0.

---
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : MIPS IF stage - PC register, instruction fetch, IF/ID register
// Revision   : 1.0
// ============================================================================
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] IM_LO      = 32'h0000_3000,
   parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] npc_in,
   input  logic        jump_d,
   input  logic        eret_d,
   input  logic        exc_req,
   output logic [31:0] im_addr,
   input  logic [31:0] im_rdata,
   output logic [31:0] pc_f,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc8_d,
   output logic [4:0]  exc_d,
   output logic        bd_d
);

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_bad;

   assign pc_plus4  = pc + 32'd4;
   assign fetch_bad = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
   assign im_addr   = pc;
   assign pc_f      = pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (exc_req) begin
         pc <= HANDLER_PC;
      end else if (!stall) begin
         pc <= br_taken ? npc_in : pc_plus4;
      end
   end

   // eret has no delay slot, so the word fetched alongside it becomes a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_d <= 32'd0;
         exc_d   <= EXC_NONE;
         bd_d    <= 1'b0;
         pc_d    <= RESET_PC;
         pc8_d   <= RESET_PC + 32'd8;
      end else if (exc_req) begin
         instr_d <= 32'd0;
         exc_d   <= EXC_NONE;
         bd_d    <= 1'b0;
         pc_d    <= HANDLER_PC;
         pc8_d   <= HANDLER_PC + 32'd8;
      end else if (!stall) begin
         if (eret_d) begin
            instr_d <= 32'd0;
            exc_d   <= EXC_NONE;
            bd_d    <= 1'b0;
            pc_d    <= npc_in;
            pc8_d   <= npc_in + 32'd8;
         end else begin
            instr_d <= fetch_bad ? 32'd0 : im_rdata;
            exc_d   <= fetch_bad ? EXC_ADEL : EXC_NONE;
            bd_d    <= jump_d;
            pc_d    <= pc;
            pc8_d   <= pc + 32'd8;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : directed self-checking bench for fetch_unit
// Revision      : 1.0
// ============================================================================
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset, stall, br_taken, jump_d, eret_d, exc_req;
   logic [31:0] npc_in, im_addr, im_rdata, pc_f, instr_d, pc_d, pc8_d;
   logic [4:0]  exc_d;
   logic        bd_d;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Instruction memory: every address yields a distinct word.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return 32'hC0DE_0000 ^ {a[15:0], a[15:0]};
   endfunction

   assign im_rdata = mem(im_addr);

   fetch_unit dut (
      .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
      .npc_in(npc_in), .jump_d(jump_d), .eret_d(eret_d), .exc_req(exc_req),
      .im_addr(im_addr), .im_rdata(im_rdata), .pc_f(pc_f), .instr_d(instr_d),
      .pc_d(pc_d), .pc8_d(pc8_d), .exc_d(exc_d), .bd_d(bd_d)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_d(input string tag, input logic [31:0] pf, input logic [31:0] ins,
                        input logic [31:0] pd, input logic [4:0] ex, input logic bd);
      chk({tag, ".pc_f"},    pc_f,    pf);
      chk({tag, ".im_addr"}, im_addr, pf);
      chk({tag, ".instr_d"}, instr_d, ins);
      chk({tag, ".pc_d"},    pc_d,    pd);
      chk({tag, ".pc8_d"},   pc8_d,   pd + 32'd8);
      chk({tag, ".exc_d"},   {27'd0, exc_d}, {27'd0, ex});
      chk({tag, ".bd_d"},    {31'd0, bd_d},  {31'd0, bd});
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1; stall = 0; br_taken = 0; jump_d = 0; eret_d = 0; exc_req = 0;
      npc_in = 32'd0;
      step();
      chk_d("reset", 32'h3000, 32'd0, 32'h3000, 5'd0, 1'b0);
      reset = 0;

      step(); chk_d("seq0", 32'h3004, mem(32'h3000), 32'h3000, 5'd0, 1'b0);
      step(); chk_d("seq1", 32'h3008, mem(32'h3004), 32'h3004, 5'd0, 1'b0);
      step(); chk_d("seq2", 32'h300C, mem(32'h3008), 32'h3008, 5'd0, 1'b0);
      step();
      chk("pc_before_beq", pc_f, 32'h3010);

      // taken branch: word at 0x3010 is the delay slot
      br_taken = 1; jump_d = 1; npc_in = 32'h3040;
      step(); chk_d("beq", 32'h3040, mem(32'h3010), 32'h3010, 5'd0, 1'b1);
      br_taken = 0; jump_d = 0;
      step(); chk_d("target", 32'h3044, mem(32'h3040), 32'h3040, 5'd0, 1'b0);

      // stall over a pending redirect
      br_taken = 1; npc_in = 32'h3080; stall = 1;
      for (int i = 0; i < 2; i++) begin
         step(); chk_d("stall", 32'h3044, mem(32'h3040), 32'h3040, 5'd0, 1'b0);
      end
      stall = 0;
      step(); chk_d("unstall", 32'h3080, mem(32'h3044), 32'h3044, 5'd0, 1'b0);

      // misaligned fetch
      npc_in = 32'h3002;
      step(); chk("pc_mis", pc_f, 32'h3002);
      br_taken = 0;
      step(); chk_d("adel_mis", 32'h3006, 32'd0, 32'h3002, 5'd4, 1'b0);

      // above range
      br_taken = 1; npc_in = 32'h7000;
      step(); chk("pc_hi", pc_f, 32'h7000);
      br_taken = 0;
      step(); chk_d("adel_hi", 32'h7004, 32'd0, 32'h7000, 5'd4, 1'b0);

      // top legal word, then fall off the end
      br_taken = 1; npc_in = 32'h6FFC;
      step(); br_taken = 0;
      step(); chk_d("edge_hi", 32'h7000, mem(32'h6FFC), 32'h6FFC, 5'd0, 1'b0);
      step(); chk_d("past_hi", 32'h7004, 32'd0, 32'h7000, 5'd4, 1'b0);

      // below range and PC+4 wrap to zero
      br_taken = 1; npc_in = 32'hFFFF_FFFC;
      step(); br_taken = 0;
      step(); chk_d("wrap", 32'h0000_0000, 32'd0, 32'hFFFF_FFFC, 5'd4, 1'b0);
      step(); chk_d("below_lo", 32'h0000_0004, 32'd0, 32'h0, 5'd4, 1'b0);

      // exception overrides stall
      exc_req = 1; stall = 1; br_taken = 1; npc_in = 32'h3100;
      step(); chk_d("exc", 32'h4180, 32'd0, 32'h4180, 5'd0, 1'b0);
      exc_req = 0; stall = 0; br_taken = 0;
      step(); chk_d("handler", 32'h4184, mem(32'h4180), 32'h4180, 5'd0, 1'b0);

      // eret: bubble, redirect
      eret_d = 1; br_taken = 1; npc_in = 32'h3020;
      step(); chk_d("eret", 32'h3020, 32'd0, 32'h3020, 5'd0, 1'b0);
      eret_d = 0; br_taken = 0;
      step(); chk_d("post_eret", 32'h3024, mem(32'h3020), 32'h3020, 5'd0, 1'b0);

      // reset mid-stream
      reset = 1;
      step(); chk_d("reset_mid", 32'h3000, 32'd0, 32'h3000, 5'd0, 1'b0);
      reset = 0;
      step(); chk_d("after_reset", 32'h3004, mem(32'h3000), 32'h3000, 5'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
